// File: rtl/align_stage_wr.sv
// align_stage_wr: realigns packed VLSU write bursts to their AW byte offset, generating strobes and w_last.
// Optional macro ALIGN_WR_ZERO_PAD_EN forces bytes with a cleared strobe to 0x00.
module align_stage_wr #(
  parameter int AxiDataWidth = 64,
  parameter int AxiAddrWidth = 64,
  parameter int NumTrackers  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      s_aw_valid_i,
  output logic                      s_aw_ready_o,
  input  logic [AxiAddrWidth-1:0]   s_aw_addr_i,
  input  logic [7:0]                s_aw_len_i,
  output logic                      m_aw_valid_o,
  input  logic                      m_aw_ready_i,
  output logic [AxiAddrWidth-1:0]   m_aw_addr_o,
  output logic [7:0]                m_aw_len_o,
  input  logic                      s_w_valid_i,
  output logic                      s_w_ready_o,
  input  logic [AxiDataWidth-1:0]   s_w_data_i,
  input  logic [AxiDataWidth/8-1:0] s_w_strb_i,
  output logic                      m_w_valid_o,
  input  logic                      m_w_ready_i,
  output logic [AxiDataWidth-1:0]   m_w_data_o,
  output logic [AxiDataWidth/8-1:0] m_w_strb_o,
  output logic                      m_w_last_o,
  input  logic                      m_b_valid_i,
  output logic                      m_b_ready_o,
  input  logic [1:0]                m_b_resp_i,
  output logic                      s_b_valid_o,
  input  logic                      s_b_ready_i,
  output logic [1:0]                s_b_resp_o
);
  localparam int B    = AxiDataWidth / 8;
  localparam int OffW = $clog2(B);
  localparam int PtrW = $clog2(NumTrackers);
  localparam int CntW = PtrW + 1;
  logic [OffW-1:0]         trk_off_q [NumTrackers];
  logic [7:0]              trk_len_q [NumTrackers];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [7:0]              beat_q, beat_d;
  logic [AxiDataWidth-1:0] carry_data_q, carry_data_d, out_data_q, out_data_d, al_data;
  logic [B-1:0]            carry_strb_q, carry_strb_d, out_strb_q, out_strb_d, al_strb;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                    full, push, pop, w_hs, last;
  logic [OffW-1:0]         off;
  assign m_aw_valid_o = s_aw_valid_i;
  assign m_aw_addr_o  = s_aw_addr_i;
  assign m_aw_len_o   = s_aw_len_i;
  assign s_b_valid_o  = m_b_valid_i;
  assign s_b_resp_o   = m_b_resp_i;
  assign m_b_ready_o  = s_b_ready_i;
  assign full         = cnt_q == CntW'(NumTrackers);
  assign s_aw_ready_o = m_aw_ready_i && !full;
  assign push         = s_aw_valid_i && s_aw_ready_o;
  assign s_w_ready_o  = (cnt_q != '0) && (!out_valid_q || m_w_ready_i);
  assign w_hs         = s_w_valid_i && s_w_ready_o;
  assign off          = trk_off_q[rd_ptr_q];
  assign last         = beat_q == trk_len_q[rd_ptr_q];
  assign pop          = w_hs && last;
  assign m_w_valid_o  = out_valid_q;
  assign m_w_data_o   = out_data_q;
  assign m_w_strb_o   = out_strb_q;
  assign m_w_last_o   = out_last_q;
  always_comb begin
    al_data = (s_w_data_i << (8 * int'(off))) | carry_data_q;
    al_strb = (s_w_strb_i << off) | carry_strb_q;
`ifdef ALIGN_WR_ZERO_PAD_EN
    for (int i = 0; i < B; i++) al_data[8*i +: 8] = al_strb[i] ? al_data[8*i +: 8] : 8'h00;
`endif
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d        = cnt_q + CntW'(push) - CntW'(pop);
    beat_d       = pop ? '0 : w_hs ? beat_q + 8'd1 : beat_q;
    // The upper off bytes of each beat spill into the low bytes of the next output beat.
    carry_data_d = pop ? '0 : w_hs ? s_w_data_i >> (AxiDataWidth - 8 * int'(off)) : carry_data_q;
    carry_strb_d = pop ? '0 : w_hs ? s_w_strb_i >> (B - int'(off)) : carry_strb_q;
    out_valid_d  = w_hs || (out_valid_q && !m_w_ready_i);
    out_data_d   = w_hs ? al_data : out_data_q;
    out_strb_d   = w_hs ? al_strb : out_strb_q;
    out_last_d   = w_hs ? last : out_last_q;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      trk_off_q[wr_ptr_q] <= s_aw_addr_i[OffW-1:0];
      trk_len_q[wr_ptr_q] <= s_aw_len_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      beat_q       <= '0;
      carry_data_q <= '0;
      carry_strb_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      carry_data_q <= carry_data_d;
      carry_strb_q <= carry_strb_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_last_q   <= out_last_d;
    end
  end
endmodule

// File: tb/tb_align_stage_wr.sv
// tb_align_stage_wr: directed and randomized checks of align_stage_wr against a byte-stream reference model.
module tb_align_stage_wr;
  logic        clk_i = 1'b0, rst_i;
  logic        s_aw_valid_i, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i;
  logic [63:0] s_aw_addr_i, m_aw_addr_o;
  logic [7:0]  s_aw_len_i, m_aw_len_o;
  logic        s_w_valid_i, s_w_ready_o, m_w_valid_o, m_w_ready_i, m_w_last_o;
  logic [63:0] s_w_data_i, m_w_data_o;
  logic [7:0]  s_w_strb_i, m_w_strb_o;
  logic        m_b_valid_i, m_b_ready_o, s_b_valid_o, s_b_ready_i;
  logic [1:0]  m_b_resp_i, s_b_resp_o;
  int checks = 0, failures = 0;
  logic [63:0] cur_d [256];
  logic [7:0]  cur_s [256];
  logic [63:0] aw_a[$], win_d[$], exp_d[$];
  logic [7:0]  aw_l[$], win_s[$], exp_s[$];
  logic        exp_l[$];
  logic [63:0] ed, sd;
  logic [7:0]  es, ss;
  logic        sl;

  align_stage_wr dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .s_aw_addr_i(s_aw_addr_i), .s_aw_len_i(s_aw_len_i),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_addr_o(m_aw_addr_o), .m_aw_len_o(m_aw_len_o),
    .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o), .s_w_data_i(s_w_data_i), .s_w_strb_i(s_w_strb_i),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o),
    .m_w_last_o(m_w_last_o),
    .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o), .m_b_resp_i(m_b_resp_i),
    .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i), .s_b_resp_o(s_b_resp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Output byte b of beat k is byte (k*8+b-off) of the concatenated packed input stream.
  function automatic void model(input int off, input int k, output logic [63:0] d, output logic [7:0] s);
    d = '0;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      int g = k * 8 + b - off;
      if (g >= 0) begin
        d[8*b +: 8] = cur_d[g / 8][8*(g % 8) +: 8];
        s[b]        = cur_s[g / 8][g % 8];
      end
    end
  endfunction

  function automatic logic [63:0] bmask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic aw_send(input logic [63:0] a, input logic [7:0] l);
    s_aw_valid_i = 1'b1;
    s_aw_addr_i  = a;
    s_aw_len_i   = l;
    #1;
    check("aw_ready", s_aw_ready_o, 1'b1);
    tick();
    s_aw_valid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s);
    s_w_valid_i = 1'b1;
    s_w_data_i  = d;
    s_w_strb_i  = s;
    #1;
    check("w_ready", s_w_ready_o, 1'b1);
    tick();
    s_w_valid_i = 1'b0;
  endtask

  task automatic check_out(input string tag, input int off, input int k, input logic lst);
    model(off, k, ed, es);
    check({tag, "_valid"}, m_w_valid_o, 1'b1);
    check({tag, "_strb"}, m_w_strb_o, es);
    check({tag, "_last"}, m_w_last_o, lst);
    check({tag, "_data"}, m_w_data_o & bmask(es), ed & bmask(es));
  endtask

  initial begin
    rst_i = 1'b1;
    s_aw_valid_i = 0; s_aw_addr_i = 0; s_aw_len_i = 0; m_aw_ready_i = 1;
    s_w_valid_i = 0; s_w_data_i = 0; s_w_strb_i = 0; m_w_ready_i = 1;
    m_b_valid_i = 0; m_b_resp_i = 0; s_b_ready_i = 0;
    repeat (2) tick();
    rst_i = 1'b0;
    check("rst_w_valid", m_w_valid_o, 1'b0);
    check("rst_w_data", m_w_data_o, 64'h0);
    check("rst_w_strb", m_w_strb_o, 8'h0);
    check("rst_w_last", m_w_last_o, 1'b0);
    check("rst_w_ready", s_w_ready_o, 1'b0);
    check("rst_aw_ready", s_aw_ready_o, 1'b1);

    aw_send(64'h1000, 8'd0);
    w_beat(64'h8877665544332211, 8'hFF);
    check("t1_data", m_w_data_o, 64'h8877665544332211);
    check("t1_strb", m_w_strb_o, 8'hFF);
    check("t1_last", m_w_last_o, 1'b1);
    tick();
    check("t1_drained", m_w_valid_o, 1'b0);
    check("t1_empty", s_w_ready_o, 1'b0);

    aw_send(64'h1003, 8'd1);
    w_beat(64'h8877665544332211, 8'hFF);
    sd = m_w_data_o;
    check("t2_out0_hi", sd[63:24], 40'h5544332211);
    check("t2_out0_strb", m_w_strb_o, 8'hF8);
    check("t2_out0_last", m_w_last_o, 1'b0);
`ifdef ALIGN_WR_ZERO_PAD_EN
    check("t2_out0_pad", m_w_data_o, 64'h5544332211000000);
`endif
    w_beat(64'h000000EEDDCCBBAA, 8'h1F);
    check("t2_out1_data", m_w_data_o, 64'hEEDDCCBBAA887766);
    check("t2_out1_strb", m_w_strb_o, 8'hFF);
    check("t2_out1_last", m_w_last_o, 1'b1);
    tick();

    cur_d[0] = 64'h8877665544332211;
    cur_s[0] = 8'hFF;
    for (int i = 0; i < 8; i++) aw_send(64'h2000 + 64'(i), 8'd0);
    s_aw_valid_i = 1'b1;
    s_aw_addr_i  = 64'h2005;
    #1;
    check("t3_full", s_aw_ready_o, 1'b0);
    tick();
    check("t3_full_hold", s_aw_ready_o, 1'b0);
    w_beat(cur_d[0], cur_s[0]);
    check("t3_ready_after_pop", s_aw_ready_o, 1'b1);
    check_out("t3_b0", 0, 0, 1'b1);
    tick();
    s_aw_valid_i = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      w_beat(cur_d[0], cur_s[0]);
      check_out("t3_wrap", j < 8 ? j : 5, 0, 1'b1);
    end
    tick();
    check("t3_empty", s_w_ready_o, 1'b0);

    for (int k = 0; k < 4; k++) begin
      cur_d[k] = {32'($urandom), 32'($urandom)};
      cur_s[k] = 8'($urandom);
    end
    aw_send(64'h3002, 8'd3);
    w_beat(cur_d[0], cur_s[0]);
    check_out("t4_b0", 2, 0, 1'b0);
    sd = m_w_data_o; ss = m_w_strb_o; sl = m_w_last_o;
    m_w_ready_i = 1'b0;
    s_w_valid_i = 1'b1; s_w_data_i = cur_d[1]; s_w_strb_i = cur_s[1];
    #1;
    check("t4_stall_ready", s_w_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_valid", m_w_valid_o, 1'b1);
      check("t4_hold_data", m_w_data_o, sd);
      check("t4_hold_strb", m_w_strb_o, ss);
      check("t4_hold_last", m_w_last_o, sl);
      check("t4_hold_wready", s_w_ready_o, 1'b0);
    end
    m_w_ready_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      w_beat(cur_d[k], cur_s[k]);
      check_out("t4_beat", 2, k, k == 3);
    end
    tick();
    check("t4_drained", m_w_valid_o, 1'b0);

    aw_send(64'h4000, 8'd3);
    w_beat(64'h1122334455667788, 8'hFF);
    check("t5_pre_valid", m_w_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("t5_rst_valid", m_w_valid_o, 1'b0);
    check("t5_rst_data", m_w_data_o, 64'h0);
    check("t5_rst_wready", s_w_ready_o, 1'b0);
    tick();
    rst_i = 1'b0;
    aw_send(64'h4005, 8'd0);
    w_beat(64'h8877665544332211, 8'hFF);
    check("t5_strb", m_w_strb_o, 8'hE0);
    check("t5_last", m_w_last_o, 1'b1);
    check("t5_data", m_w_data_o & 64'hFFFFFF0000000000, 64'h3322110000000000);
    tick();

    for (int n = 0; n < 20; n++) begin
      int off = $urandom_range(0, 7);
      int len = $urandom_range(0, 4);
      aw_a.push_back({32'($urandom), 32'($urandom)} & ~64'h7 | 64'(off));
      aw_l.push_back(8'(len));
      for (int k = 0; k <= len; k++) begin
        cur_d[k] = {32'($urandom), 32'($urandom)};
        cur_s[k] = 8'($urandom);
        win_d.push_back(cur_d[k]);
        win_s.push_back(cur_s[k]);
      end
      for (int k = 0; k <= len; k++) begin
        model(off, k, ed, es);
        exp_d.push_back(ed);
        exp_s.push_back(es);
        exp_l.push_back(k == len);
      end
    end
    for (int cyc = 0; cyc < 5000 && exp_d.size() > 0; cyc++) begin
      s_aw_valid_i = (aw_a.size() > 0) && ($urandom_range(0, 3) != 0);
      if (aw_a.size() > 0) begin
        s_aw_addr_i = aw_a[0];
        s_aw_len_i  = aw_l[0];
      end
      m_aw_ready_i = $urandom_range(0, 4) != 0;
      s_w_valid_i  = (win_d.size() > 0) && ($urandom_range(0, 3) != 0);
      if (win_d.size() > 0) begin
        s_w_data_i = win_d[0];
        s_w_strb_i = win_s[0];
      end
      m_w_ready_i = $urandom_range(0, 3) != 0;
      m_b_valid_i = 1'($urandom);
      m_b_resp_i  = 2'($urandom);
      s_b_ready_i = 1'($urandom);
      #1;
      if (m_w_valid_o && m_w_ready_i) begin
        check("rnd_strb", m_w_strb_o, exp_s[0]);
        check("rnd_last", m_w_last_o, exp_l[0]);
        check("rnd_data", m_w_data_o & bmask(exp_s[0]), exp_d[0] & bmask(exp_s[0]));
        void'(exp_d.pop_front()); void'(exp_s.pop_front()); void'(exp_l.pop_front());
      end
      if (s_aw_valid_i && s_aw_ready_o) begin
        check("rnd_aw_pass", {m_aw_valid_o, m_aw_len_o, m_aw_addr_o[54:0]}, {1'b1, aw_l[0], aw_a[0][54:0]});
        void'(aw_a.pop_front()); void'(aw_l.pop_front());
      end
      if (s_w_valid_i && s_w_ready_o) begin
        void'(win_d.pop_front()); void'(win_s.pop_front());
      end
      if (cyc % 16 == 0)
        check("rnd_b_pass", {s_b_valid_o, s_b_resp_o, m_b_ready_o}, {m_b_valid_i, m_b_resp_i, s_b_ready_i});
      tick();
    end
    check("rnd_all_beats_out", 64'(exp_d.size()), 64'd0);
    s_aw_valid_i = 1'b0;
    s_w_valid_i  = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
